// File: rtl/alu_mdu.sv
// alu_mdu: registered ALU with an iterative multiply/divide unit.
//
// Single-cycle ops (AND/OR/LUI/ADD/SLL/NOR/SRL/SUB/SLT/SRA/MFLO/MFHI) register
// their result into ALUResult/Zero one edge after an accepted start. MULT,
// MULTU, DIV and DIVU run one shift-add / restoring-subtract step per cycle,
// then a sign-fixup cycle writes HI/LO. Latency is WIDTH+1 edges after accept.
//
// Ports:
//   clk, reset (async, active low)
//   start, ALUOperation[3:0], A, B  - issue request, taken only when busy=0
//   busy, done                      - iterative op in flight / one-cycle result pulse
//   ALUResult, Zero                 - registered ALU result and its zero flag
//   HI, LO                          - product high/low or remainder/quotient
//   DivByZero                       - sticky until the next accepted start
//
// state | meaning
// IDLE  | waiting for start; single-cycle ops complete from here
// MUL   | WIDTH shift-add steps over {acc, mq}
// DIV   | WIDTH restoring-divide steps, quotient shifted into mq
// FIX   | sign fixup, HI/LO written, done pulsed
module alu_mdu #(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ALUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             DivByZero
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_LUI   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MFLO  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_MFHI  = 4'b1111;

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
  logic [WIDTH-1:0] mq_q, mq_d;       // multiplier -> product low half / dividend -> quotient
  logic [WIDTH-1:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             is_div_q, is_div_d;
  logic             dbz_q, dbz_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_sticky_q, dbz_sticky_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             is_iter, is_signed, is_div_op, b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_r;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign shamt = B[SHW-1:0];

  always_comb begin
    alu_res = '0;
    unique case (ALUOperation)
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_LUI:  alu_res = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_ADD:  alu_res = A + B;
      OP_SLL:  alu_res = A << shamt;
      OP_NOR:  alu_res = ~(A | B);
      OP_SRL:  alu_res = A >> shamt;
      OP_SUB:  alu_res = A - B;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SRA:  alu_res = $signed(A) >>> shamt;
      OP_MFLO: alu_res = lo_q;
      OP_MFHI: alu_res = hi_q;
      default: alu_res = '0;
    endcase
  end

  assign is_iter   = (ALUOperation == OP_MULTU) || (ALUOperation == OP_MULT) ||
                     (ALUOperation == OP_DIVU)  || (ALUOperation == OP_DIV);
  assign is_signed = (ALUOperation == OP_MULT) || (ALUOperation == OP_DIV);
  assign is_div_op = (ALUOperation == OP_DIVU) || (ALUOperation == OP_DIV);
  assign b_zero    = (B == '0);
  assign a_neg     = is_signed & A[WIDTH-1];
  assign b_neg     = is_signed & B[WIDTH-1];
  // |MIN| = 2^(WIDTH-1) still fits as an unsigned WIDTH-bit magnitude.
  assign a_mag     = a_neg ? (~A + 1'b1) : A;
  assign b_mag     = b_neg ? (~B + 1'b1) : B;

  assign mul_sum  = {1'b0, acc_q} + (mq_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign div_r    = {acc_q, mq_q[WIDTH-1]};
  assign div_ge   = (div_r >= {1'b0, mcand_q});
  // When div_ge holds the difference is below the divisor, so WIDTH bits suffice.
  assign div_diff = div_r[WIDTH-1:0] - mcand_q;

  assign prod     = {acc_q, mq_q};
  assign prod_fix = neg_lo_q ? (~prod + 1'b1) : prod;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    mq_d         = mq_q;
    mcand_d      = mcand_q;
    neg_lo_d     = neg_lo_q;
    neg_hi_d     = neg_hi_q;
    is_div_d     = is_div_q;
    dbz_d        = dbz_q;
    done_d       = 1'b0;
    res_d        = res_q;
    zero_d       = zero_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    dbz_sticky_d = dbz_sticky_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          dbz_sticky_d = 1'b0;
          if (is_iter) begin
            cnt_d    = CW'(WIDTH);
            acc_d    = '0;
            is_div_d = is_div_op;
            dbz_d    = is_div_op & b_zero;
            if (is_div_op) begin
              state_d  = ST_DIV;
              mq_d     = a_mag;
              mcand_d  = b_mag;
              // Divide by zero keeps LO all ones, so the quotient is never negated.
              neg_lo_d = (a_neg ^ b_neg) & ~b_zero;
              neg_hi_d = a_neg;
            end else begin
              state_d  = ST_MUL;
              mq_d     = b_mag;
              mcand_d  = a_mag;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
            end
          end else begin
            res_d  = alu_res;
            zero_d = (alu_res == '0);
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d = mul_sum[WIDTH:1];
        mq_d  = {mul_sum[0], mq_q[WIDTH-1:1]};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_DIV: begin
        // With a zero divisor every step subtracts nothing: quotient all ones,
        // remainder equals the dividend magnitude.
        acc_d = div_ge ? div_diff : div_r[WIDTH-1:0];
        mq_d  = {mq_q[WIDTH-2:0], div_ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        if (is_div_q) begin
          lo_d = neg_lo_q ? (~mq_q + 1'b1) : mq_q;
          hi_d = neg_hi_q ? (~acc_q + 1'b1) : acc_q;
        end else begin
          lo_d = prod_fix[WIDTH-1:0];
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
        end
        if (dbz_q) dbz_sticky_d = 1'b1;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      mq_q         <= '0;
      mcand_q      <= '0;
      neg_lo_q     <= 1'b0;
      neg_hi_q     <= 1'b0;
      is_div_q     <= 1'b0;
      dbz_q        <= 1'b0;
      done_q       <= 1'b0;
      res_q        <= '0;
      zero_q       <= 1'b1;
      hi_q         <= '0;
      lo_q         <= '0;
      dbz_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      mq_q         <= mq_d;
      mcand_q      <= mcand_d;
      neg_lo_q     <= neg_lo_d;
      neg_hi_q     <= neg_hi_d;
      is_div_q     <= is_div_d;
      dbz_q        <= dbz_d;
      done_q       <= done_d;
      res_q        <= res_d;
      zero_q       <= zero_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      dbz_sticky_q <= dbz_sticky_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign ALUResult = res_q;
  assign Zero      = zero_q;
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign DivByZero = dbz_sticky_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed bench for alu_mdu (WIDTH=32): single-cycle op table plus
// hand-written multiply/divide, ignored-start and mid-op reset sequences.
module tb_alu_mdu;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_LUI   = 4'b0010;
  localparam logic [3:0] OP_ADD   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SUB   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SRA   = 4'b1001;
  localparam logic [3:0] OP_MFLO  = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1011;
  localparam logic [3:0] OP_MULT  = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_DIV   = 4'b1110;
  localparam logic [3:0] OP_MFHI  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, dbz;
  logic [31:0] res, hi, lo;

  int checks = 0;
  int errors = 0;

  alu_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUOperation(op),
    .A(a), .B(b), .busy(busy), .done(done), .ALUResult(res), .Zero(zero),
    .HI(hi), .LO(lo), .DivByZero(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        zero;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic go(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits for done after an accept edge; optionally raises start with an ADD
  // for the edge numbered inject. Returns the edge count (0 on timeout).
  task automatic wait_done(input int inject, output int lat);
    lat = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e == inject) begin
        @(negedge clk);
        op = OP_ADD; a = 32'd1; b = 32'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = e;
        break;
      end
    end
  endtask

  task automatic run_iter(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic edbz);
    int lat;
    go(o, x, y);
    chk({name, " busy"}, {31'd0, busy}, 32'd1);
    wait_done(0, lat);
    chk({name, " latency"}, lat, 32'd33);
    chk({name, " HI"}, hi, ehi);
    chk({name, " LO"}, lo, elo);
    chk({name, " dbz"}, {31'd0, dbz}, {31'd0, edbz});
    chk({name, " busy after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;
    reset = 1'b0; start = 1'b0; op = 4'd0; a = '0; b = '0;

    vecs.push_back('{OP_MFHI, 32'h0,        32'h0,        32'h0,        1'b1});
    vecs.push_back('{OP_MFLO, 32'h0,        32'h0,        32'h0,        1'b1});
    vecs.push_back('{OP_ADD,  32'd5,        32'd7,        32'h0000000C, 1'b0});
    vecs.push_back('{OP_SUB,  32'd7,        32'd7,        32'h0,        1'b1});
    vecs.push_back('{OP_SUB,  32'd3,        32'd5,        32'hFFFFFFFE, 1'b0});
    vecs.push_back('{OP_ADD,  32'hFFFFFFFF, 32'd1,        32'h0,        1'b1});
    vecs.push_back('{OP_AND,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 1'b0});
    vecs.push_back('{OP_OR,   32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0});
    vecs.push_back('{OP_NOR,  32'h0,        32'h0,        32'hFFFFFFFF, 1'b0});
    vecs.push_back('{OP_LUI,  32'h0000DEAD, 32'h00001234, 32'h12340000, 1'b0});
    vecs.push_back('{OP_SLL,  32'd1,        32'd31,       32'h80000000, 1'b0});
    vecs.push_back('{OP_SLL,  32'd3,        32'h00000021, 32'h00000006, 1'b0});
    vecs.push_back('{OP_SRL,  32'h80000000, 32'd4,        32'h08000000, 1'b0});
    vecs.push_back('{OP_SRA,  32'h80000000, 32'd4,        32'hF8000000, 1'b0});
    vecs.push_back('{OP_SRA,  32'h40000000, 32'd4,        32'h04000000, 1'b0});
    vecs.push_back('{OP_SLT,  32'hFFFFFFFF, 32'd1,        32'h00000001, 1'b0});
    vecs.push_back('{OP_SLT,  32'd1,        32'hFFFFFFFF, 32'h0,        1'b1});

    repeat (2) @(posedge clk);
    #1;
    chk("rst ALUResult", res, 32'h0);
    chk("rst Zero", {31'd0, zero}, 32'd1);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst HI", hi, 32'h0);
    chk("rst LO", lo, 32'h0);
    chk("rst DivByZero", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Back-to-back single-cycle ops: start held high for the whole table.
    foreach (vecs[i]) begin
      @(negedge clk);
      op = vecs[i].op; a = vecs[i].a; b = vecs[i].b; start = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("vec%0d result", i), res, vecs[i].res);
      chk($sformatf("vec%0d zero", i), {31'd0, zero}, {31'd0, vecs[i].zero});
      chk($sformatf("vec%0d done", i), {31'd0, done}, 32'd1);
      chk($sformatf("vec%0d busy", i), {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done one cycle", {31'd0, done}, 32'd0);

    run_iter("MULT -3*7", OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    @(posedge clk); #1;
    chk("done after MULT", {31'd0, done}, 32'd0);
    go(OP_MFLO, 32'h0, 32'h0);
    chk("MFLO", res, 32'hFFFFFFEB);
    go(OP_MFHI, 32'h0, 32'h0);
    chk("MFHI", res, 32'hFFFFFFFF);

    // MULTU with an ADD start at edge 5 that must be ignored.
    go(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(5, lat);
    chk("MULTU latency", lat, 32'd33);
    chk("MULTU HI", hi, 32'hFFFFFFFE);
    chk("MULTU LO", lo, 32'h00000001);
    chk("MULTU ALUResult kept", res, 32'hFFFFFFFF);
    chk("MULTU Zero kept", {31'd0, zero}, 32'd0);

    run_iter("DIV -7/2", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    run_iter("DIV 7/-2", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
    run_iter("DIVU 100/7", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
    run_iter("DIVU 9/0", OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b1);
    @(posedge clk); #1;
    chk("dbz sticky", {31'd0, dbz}, 32'd1);
    run_iter("DIV -5/0", OP_DIV, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    run_iter("DIV MIN/-1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 1'b0);

    // Reset in the middle of a DIV.
    go(OP_ADD, 32'd1, 32'd2);
    chk("pre-reset ADD", res, 32'd3);
    go(OP_DIV, 32'd100, 32'd3);
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("mid-rst busy", {31'd0, busy}, 32'd0);
    chk("mid-rst done", {31'd0, done}, 32'd0);
    chk("mid-rst HI", hi, 32'h0);
    chk("mid-rst LO", lo, 32'h0);
    chk("mid-rst ALUResult", res, 32'h0);
    chk("mid-rst Zero", {31'd0, zero}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("no done after abort", {31'd0, done}, 32'd0);
    go(OP_ADD, 32'd1, 32'd1);
    chk("post-rst ADD", res, 32'd2);
    chk("post-rst done", {31'd0, done}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
